// File: rtl/uart_pkg.sv
// Register map, STATUS bit positions and transmitter state type shared by the
// MMIO UART transmitter and its queue.
package uart_pkg;

  localparam logic [3:0] OFF_TXDATA  = 4'h0;
  localparam logic [3:0] OFF_STATUS  = 4'h4;
  localparam logic [3:0] OFF_BAUDDIV = 4'h8;

  localparam int STATUS_BUSY = 0;
  localparam int STATUS_FULL = 1;
  localparam int STATUS_OVF  = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

  // Byte offset of the register addressed by word index addr[3:2].
  function automatic logic [3:0] reg_offset(input logic [1:0] word_idx);
    return {word_idx, 2'b00};
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit byte queue. UART_TX_FIFO_EN selects a 4-entry circular FIFO;
// otherwise a single holding register. A push while full is accepted only with a pop.
module uart_tx_fifo (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       full,
  output logic       empty
);

`ifdef UART_TX_FIFO_EN
  logic [7:0] mem_q [4];
  logic [7:0] mem_d [4];
  logic [1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;
  logic       push_ok, pop_ok;

  assign full    = (count_q == 3'd4);
  assign empty   = (count_q == 3'd0);
  assign data_o  = mem_q[rd_ptr_q];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (pop_ok) rd_ptr_d = rd_ptr_q + 2'd1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
`else
  logic [7:0] hold_q, hold_d;
  logic       valid_q, valid_d;
  logic       push_ok, pop_ok;

  assign full    = valid_q;
  assign empty   = !valid_q;
  assign data_o  = hold_q;
  assign pop_ok  = pop && valid_q;
  assign push_ok = push && (!valid_q || pop_ok);

  always_comb begin
    hold_d  = hold_q;
    valid_d = valid_q;
    if (pop_ok) valid_d = 1'b0;
    if (push_ok) begin
      hold_d  = data_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_q  <= 8'd0;
      valid_q <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      valid_q <= valid_d;
    end
  end
`endif

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA / STATUS / BAUDDIV registers.
// Define UART_TX_FIFO_EN for a 4-deep transmit FIFO instead of one holding register.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
  parameter logic [15:0] DIV_RESET = 16'd868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        sel_o,
  output logic        tx_o
);

  tx_state_e   state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        ovf_q, ovf_d;
  logic        tx_q, tx_d;

  logic [3:0]  offset;
  logic        wr_txdata, wr_status, wr_bauddiv;
  logic        fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_data;
  logic [2:0]  status;
  logic        unused_bits;

  assign unused_bits = ^{addr_i[1:0], data_i[31:16]};

  assign sel_o      = (addr_i[31:4] == BASE_ADDR[31:4]);
  assign offset     = reg_offset(addr_i[3:2]);
  assign wr_txdata  = we_i && sel_o && reset && (offset == OFF_TXDATA);
  assign wr_status  = we_i && sel_o && reset && (offset == OFF_STATUS);
  assign wr_bauddiv = we_i && sel_o && reset && (offset == OFF_BAUDDIV);

  uart_tx_fifo u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (wr_txdata),
    .pop    (fifo_pop),
    .data_i (data_i[7:0]),
    .data_o (fifo_data),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_comb begin
    status              = 3'b000;
    status[STATUS_BUSY] = (state_q != ST_IDLE) || !fifo_empty;
    status[STATUS_FULL] = fifo_full;
    status[STATUS_OVF]  = ovf_q;
  end

  always_comb begin
    data_o = 32'd0;
    if (sel_o) begin
      case (offset)
        OFF_STATUS:  data_o = {29'd0, status};
        OFF_BAUDDIV: data_o = {16'd0, div_q};
        default:     data_o = 32'd0;
      endcase
    end
  end

  always_comb begin
    div_d = div_q;
    if (wr_bauddiv) div_d = (data_i[15:0] == 16'd0) ? 16'd1 : data_i[15:0];
    ovf_d = ovf_q;
    if (wr_status && data_i[STATUS_OVF]) ovf_d = 1'b0;
    if (wr_txdata && fifo_full && !fifo_pop) ovf_d = 1'b1;
  end

  // Every bit boundary reloads the counter from the live divisor.
  always_comb begin
    state_d  = state_q;
    cnt_d    = (state_q == ST_IDLE) ? cnt_q : cnt_q - 16'd1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_data;
          state_d  = ST_START;
          cnt_d    = div_q - 16'd1;
        end
      end
      ST_START: begin
        if (cnt_q == 16'd0) begin
          state_d = ST_DATA;
          bit_d   = 3'd0;
          cnt_d   = div_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (cnt_q == 16'd0) begin
          cnt_d = div_q - 16'd1;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end
      ST_STOP: begin
        if (cnt_q == 16'd0) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_data;
            state_d  = ST_START;
            cnt_d    = div_q - 16'd1;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = 16'd0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      div_q   <= DIV_RESET;
      cnt_q   <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      ovf_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ovf_q   <= ovf_d;
      tx_q    <= tx_d;
    end
  end

  assign tx_o = tx_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: expected serial waveforms come from a
// per-clock line model built from byte lists and bit durations.
module tb_mmio_uart_tx;

  localparam logic [31:0] A_TX = 32'hFFFF_0000;
  localparam logic [31:0] A_ST = 32'hFFFF_0004;
  localparam logic [31:0] A_BD = 32'hFFFF_0008;
`ifdef UART_TX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = 32'd0;
  logic [31:0] data_i = 32'd0;
  logic [31:0] data_o;
  logic        sel_o;
  logic        tx_o;

  int n_checks = 0;
  int n_fail = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  mmio_uart_tx dut (
    .clk    (clk),
    .reset  (reset),
    .we_i   (we_i),
    .addr_i (addr_i),
    .data_i (data_i),
    .data_o (data_o),
    .sel_o  (sel_o),
    .tx_o   (tx_o)
  );

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d);
    we_i = we; addr_i = a; data_i = d;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, a, d);
    tick();
    drive(1'b0, a, 32'd0);
    #1;
  endtask

  // Line model: start bit, 8 data bits LSB first, stop bit, each held for its divisor.
  function automatic void add_frame(input logic [7:0] b, input int d_start, input int d_rest);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++)
      for (int c = 0; c < ((i == 0) ? d_start : d_rest); c++)
        exp_q.push_back(bits[i]);
  endfunction

  task automatic test_reset();
    repeat (2) tick();
    reset = 1'b1;
    drive(1'b0, A_ST, 32'd0);
    #1;
    n_checks++;
    if (tx_o !== 1'b1) begin n_fail++; $display("FAIL reset_tx got %b want 1", tx_o); end
    n_checks++;
    if (data_o !== 32'd0) begin n_fail++; $display("FAIL reset_status got %h want 0", data_o); end
    drive(1'b0, A_BD, 32'd0);
    #1;
    n_checks++;
    if (data_o !== 32'd868) begin n_fail++; $display("FAIL reset_bauddiv got %0d want 868", data_o); end
    $display("reset done");
  endtask

  task automatic test_frame_a5();
    bus_write(A_BD, 32'd4);
    n_checks++;
    if (data_o !== 32'd4) begin n_fail++; $display("FAIL a5_bauddiv got %0d want 4", data_o); end
    exp_q.delete();
    exp_q.push_back(1'b1);
    add_frame(8'hA5, 4, 4);
    exp_q.push_back(1'b1);
    for (int t = 0; t < exp_q.size(); t++) begin
      if (t == 0) drive(1'b1, A_TX, 32'hA5); else drive(1'b0, A_ST, 32'd0);
      tick();
      n_checks++;
      if (tx_o !== exp_q[t]) begin n_fail++; $display("FAIL a5_tx cycle %0d got %b want %b", t, tx_o, exp_q[t]); end
    end
    #1;
    n_checks++;
    if (data_o !== 32'd0) begin n_fail++; $display("FAIL a5_idle_status got %h want 0", data_o); end
    $display("tx byte a5 div 4");
  endtask

  task automatic test_div_zero();
    logic [7:0] b;
    b = 8'($urandom);
    bus_write(A_BD, 32'd0);
    n_checks++;
    if (data_o !== 32'd1) begin n_fail++; $display("FAIL div0_readback got %0d want 1", data_o); end
    exp_q.delete();
    exp_q.push_back(1'b1);
    add_frame(b, 1, 1);
    exp_q.push_back(1'b1);
    for (int t = 0; t < exp_q.size(); t++) begin
      if (t == 0) drive(1'b1, A_TX, {24'd0, b}); else drive(1'b0, A_ST, 32'd0);
      tick();
      n_checks++;
      if (tx_o !== exp_q[t]) begin n_fail++; $display("FAIL div0_tx cycle %0d got %b want %b", t, tx_o, exp_q[t]); end
    end
    #1;
    n_checks++;
    if (data_o !== 32'd0) begin n_fail++; $display("FAIL div0_idle got %h want 0", data_o); end
    $display("tx byte %02h div 1", b);
  endtask

  task automatic test_overflow();
    logic [7:0] bytes [6];
    int acc;
    acc = (DEPTH + 1 < 6) ? DEPTH + 1 : 6;
    for (int i = 0; i < 6; i++) bytes[i] = 8'($urandom);
    bus_write(A_BD, 32'd2);
    exp_q.delete();
    exp_q.push_back(1'b1);
    for (int i = 0; i < acc; i++) add_frame(bytes[i], 2, 2);
    exp_q.push_back(1'b1);
    for (int t = 0; t < exp_q.size(); t++) begin
      if (t < 6) drive(1'b1, A_TX, {24'd0, bytes[t]}); else drive(1'b0, A_ST, 32'd0);
      tick();
      n_checks++;
      if (tx_o !== exp_q[t]) begin n_fail++; $display("FAIL ovf_tx cycle %0d got %b want %b", t, tx_o, exp_q[t]); end
      if (t == 5) begin
        drive(1'b0, A_ST, 32'd0);
        #1;
        n_checks++;
        if (data_o !== 32'd7) begin n_fail++; $display("FAIL ovf_status_full got %h want 7", data_o); end
      end
    end
    #1;
    n_checks++;
    if (data_o !== 32'd4) begin n_fail++; $display("FAIL ovf_sticky got %h want 4", data_o); end
    bus_write(A_ST, 32'd4);
    n_checks++;
    if (data_o !== 32'd0) begin n_fail++; $display("FAIL ovf_clear got %h want 0", data_o); end
    $display("burst of 6 bytes div 2, %0d accepted", acc);
  endtask

  task automatic test_baud_change();
    logic [7:0] b;
    b = 8'($urandom);
    bus_write(A_BD, 32'd4);
    exp_q.delete();
    exp_q.push_back(1'b1);
    add_frame(b, 4, 8);
    exp_q.push_back(1'b1);
    for (int t = 0; t < exp_q.size(); t++) begin
      if (t == 0) drive(1'b1, A_TX, {24'd0, b});
      else if (t == 2) drive(1'b1, A_BD, 32'd8);
      else drive(1'b0, A_BD, 32'd0);
      tick();
      n_checks++;
      if (tx_o !== exp_q[t]) begin n_fail++; $display("FAIL baudchg_tx cycle %0d got %b want %b", t, tx_o, exp_q[t]); end
    end
    drive(1'b0, A_BD, 32'd0);
    #1;
    n_checks++;
    if (data_o !== 32'd8) begin n_fail++; $display("FAIL baudchg_div got %0d want 8", data_o); end
    $display("tx byte %02h div 4 then 8", b);
  endtask

  task automatic test_reset_midframe();
    bus_write(A_BD, 32'd4);
    exp_q.delete();
    exp_q.push_back(1'b1);
    add_frame(8'h00, 4, 4);
    for (int t = 0; t < 15; t++) begin
      if (t == 0) drive(1'b1, A_TX, 32'h00); else drive(1'b0, A_ST, 32'd0);
      tick();
      n_checks++;
      if (tx_o !== exp_q[t]) begin n_fail++; $display("FAIL midrst_tx cycle %0d got %b want %b", t, tx_o, exp_q[t]); end
    end
    reset = 1'b0;
    drive(1'b1, A_TX, 32'hFF);
    tick();
    reset = 1'b1;
    drive(1'b0, A_ST, 32'd0);
    #1;
    n_checks++;
    if (tx_o !== 1'b1) begin n_fail++; $display("FAIL midrst_tx_after got %b want 1", tx_o); end
    n_checks++;
    if (data_o !== 32'd0) begin n_fail++; $display("FAIL midrst_status got %h want 0", data_o); end
    drive(1'b0, A_BD, 32'd0);
    #1;
    n_checks++;
    if (data_o !== 32'd868) begin n_fail++; $display("FAIL midrst_div got %0d want 868", data_o); end
    drive(1'b0, A_ST, 32'd0);
    repeat (3) tick();
    n_checks++;
    if (data_o !== 32'd0 || tx_o !== 1'b1) begin
      n_fail++; $display("FAIL midrst_write_ignored status %h tx %b want 0 1", data_o, tx_o);
    end
    $display("reset during data bit 2");
  endtask

  task automatic test_decode();
    drive(1'b0, 32'hFFFF_000C, 32'd0);
    #1;
    n_checks++;
    if (sel_o !== 1'b1 || data_o !== 32'd0) begin
      n_fail++; $display("FAIL dec_hole sel %b data %h want 1 0", sel_o, data_o);
    end
    bus_write(32'hFFFF_000C, 32'hFFFF_FFFF);
    drive(1'b0, 32'h0000_1000, 32'd0);
    #1;
    n_checks++;
    if (sel_o !== 1'b0 || data_o !== 32'd0) begin
      n_fail++; $display("FAIL dec_outside sel %b data %h want 0 0", sel_o, data_o);
    end
    bus_write(32'h0000_1000, 32'hFFFF_FFFF);
    drive(1'b0, 32'hFFFF_000B, 32'd0);
    #1;
    n_checks++;
    if (data_o !== 32'd868) begin n_fail++; $display("FAIL dec_div_unchanged got %0d want 868", data_o); end
    drive(1'b0, A_TX, 32'd0);
    #1;
    n_checks++;
    if (sel_o !== 1'b1 || data_o !== 32'd0) begin
      n_fail++; $display("FAIL dec_txdata_read sel %b data %h want 1 0", sel_o, data_o);
    end
    drive(1'b0, A_ST, 32'd0);
    tick();
    n_checks++;
    if (data_o !== 32'd0 || tx_o !== 1'b1) begin
      n_fail++; $display("FAIL dec_no_push status %h tx %b want 0 1", data_o, tx_o);
    end
    $display("decode checks done");
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      logic [7:0] bytes [5];
      int k, div, occ;
      logic full_exp;
      k   = $urandom_range(1, DEPTH + 1);
      div = $urandom_range(1, 4);
      for (int i = 0; i < 5; i++) bytes[i] = 8'($urandom);
      occ = (k == 1) ? 1 : k - 1;
      full_exp = (occ == DEPTH);
      bus_write(A_BD, div);
      exp_q.delete();
      exp_q.push_back(1'b1);
      for (int i = 0; i < k; i++) add_frame(bytes[i], div, div);
      exp_q.push_back(1'b1);
      for (int t = 0; t < exp_q.size(); t++) begin
        if (t < k) drive(1'b1, A_TX, {24'd0, bytes[t]}); else drive(1'b0, A_ST, 32'd0);
        tick();
        n_checks++;
        if (tx_o !== exp_q[t]) begin n_fail++; $display("FAIL rand_tx iter %0d cycle %0d got %b want %b", it, t, tx_o, exp_q[t]); end
        if (t == k - 1) begin
          drive(1'b0, A_ST, 32'd0);
          #1;
          n_checks++;
          if (data_o !== {29'd0, 1'b0, full_exp, 1'b1}) begin
            n_fail++; $display("FAIL rand_status iter %0d got %h want %h", it, data_o, {29'd0, 1'b0, full_exp, 1'b1});
          end
        end
      end
      #1;
      n_checks++;
      if (data_o !== 32'd0) begin n_fail++; $display("FAIL rand_idle iter %0d got %h want 0", it, data_o); end
      $display("random burst %0d bytes div %0d first %02h", k, div, bytes[0]);
    end
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_div_zero();
    test_overflow();
    test_baud_change();
    test_random();
    test_reset_midframe();
    test_decode();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'hFFFF_0000, word-aligned base of the 3-register window.
REQ-002 SHALL have parameter DIV_RESET, default 16'd868, the reset value of BAUDDIV in clocks per bit.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-005 SHALL have port we_i, input, 1, CPU bus write strobe.
REQ-006 SHALL have port addr_i, input, 32, CPU bus address.
REQ-007 SHALL have port data_i, input, 32, CPU bus write data.
REQ-008 SHALL have port data_o, output, 32, register read data.
REQ-009 SHALL have port sel_o, output, 1, high when addr_i falls in the window; the system top uses it to mux data_o over RAM data.
REQ-010 SHALL have port tx_o, output, 1, serial line: 8N1, LSB first, idle high.

Function
REQ-011 SHALL decode three registers: TXDATA at BASE+0, STATUS at BASE+4, BAUDDIV at BASE+8; addr_i[1:0] ignored; other window offsets read 0 and ignore writes.
REQ-012 SHALL generate sel_o and data_o combinationally from addr_i and registered state, with zero-cycle read latency.
REQ-013 SHALL read STATUS as {29'b0, ovf, full, busy}: busy = shifter active or queue non-empty; full = queue full; ovf = sticky overflow.
REQ-014 SHALL push data_i[7:0] into the queue on a TXDATA write; a TXDATA read returns 0.
REQ-015 SHALL drop a TXDATA write while full and set ovf in the same edge, unless a pop occurs in that same cycle; in that case the push SHALL be accepted.
REQ-016 SHALL clear ovf on a STATUS write with data_i[2]=1; all other STATUS bits are read-only.
REQ-017 SHALL load BAUDDIV[15:0] from data_i[15:0] on a write, store a written 0 as 1, and read back {16'b0, BAUDDIV}.
REQ-018 SHALL implement FSM IDLE->START->DATA->STOP->(START if queue non-empty, else IDLE).
REQ-019 SHALL leave IDLE in the cycle after the queue becomes non-empty, popping the head byte into the shift register on that transition edge.
REQ-020 SHALL hold each of START (tx_o=0), the 8 DATA bits and STOP (tx_o=1) for exactly BAUDDIV clocks, giving a frame of 10*BAUDDIV clocks.
REQ-021 SHALL sample BAUDDIV at each bit boundary, so a mid-frame BAUDDIV write takes effect from the next bit.
REQ-022 SHALL, from STOP with the queue non-empty, pop and enter START with no idle gap.
REQ-023 SHALL register tx_o so it has no combinational path from bus inputs.

Reset
REQ-024 SHALL, with reset=0 at a clk edge, set: FSM IDLE, queue empty, ovf 0, BAUDDIV DIV_RESET, bit counters 0, tx_o 1.
REQ-025 SHALL apply reset mid-frame by aborting the frame, dropping queued bytes, and driving tx_o=1 on the next edge.
REQ-026 SHALL ignore bus writes in a cycle with reset=0.

Configuration
REQ-027 SHALL, with UART_TX_FIFO_EN defined, queue through a 4-entry circular FIFO (2-bit pointers plus 3-bit count; full at count 4).
REQ-028 SHALL, with UART_TX_FIFO_EN undefined, use a single holding register (full when occupied), with identical register map and STATUS semantics.

Structure
REQ-029 SHALL place register offsets (0, 4, 8), STATUS bit indices and the FSM state typedef in shared package uart_pkg.
REQ-030 SHALL put the queue in sub-module uart_tx_fifo (push/pop/data/full/empty), selected by UART_TX_FIFO_EN.

Verification
REQ-031 SHALL check: reset, BAUDDIV write 4, TXDATA 8'hA5 -> tx_o low 4 clks, then bits 1,0,1,0,0,1,0,1 at 4 clks each, high 4 clks; busy=0 after.
REQ-032 SHALL check, FIFO_EN, BAUDDIV=2: 6 back-to-back writes -> writes 1-5 accepted (one popped into shifter), write 6 sets ovf; 5 frames with no gaps; STATUS write 4 clears ovf.
REQ-033 SHALL check: write 0 to BAUDDIV -> reads back 1; a frame lasts 10 clks.
REQ-034 SHALL check: reset=0 in the 3rd data bit -> tx_o=1 next edge, STATUS reads 0, BAUDDIV reads 868.
REQ-035 SHALL check: addr 32'hFFFF_000C and 32'h0000_1000 -> sel_o 1/0 respectively, data_o 0, writes ignored.
REQ-036 SHALL check: BAUDDIV write 8 during a bit at BAUDDIV=4 -> current bit completes at 4 clks, following bits take 8.
